// File: rtl/addsub_share_arbiter.sv
// Shares one external 4-bit adder/subtractor between two valid/ready requesters.
// One op in flight: IDLE (arbitrate/accept) -> EXEC (drive unit) -> RESP (hold response).
module addsub_share_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic             req1_sub,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [3:0]       resp0_result,
  output logic             resp0_cout,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [3:0]       resp1_result,
  output logic             resp1_cout,
  output logic [3:0]       op_a,
  output logic [3:0]       op_b,
  output logic             op_sub,
  output logic             op_en,
  input  logic [3:0]       op_result,
  input  logic             op_cout,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_a, r_b;
  logic             r_sub, r_id, r_last;
  logic [3:0]       r_res0, r_res1;
  logic             r_cout0, r_cout1;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;
  logic             w_grant, w_rdy0, w_rdy1, w_acc, w_resp_hs;

  // Grant is the requester id; with no contention the lone valid one wins.
  always_comb begin
    w_grant = 1'b0;
    if (RR_EN && req0_valid && req1_valid) w_grant = ~r_last;
    else                                   w_grant = ~req0_valid;
    w_rdy0    = (r_state == IDLE) && !rst && req0_valid && !w_grant;
    w_rdy1    = (r_state == IDLE) && !rst && req1_valid &&  w_grant;
    w_acc     = w_rdy0 || w_rdy1;
    w_resp_hs = (r_state == RESP) && (r_id ? resp1_ready : resp0_ready);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_resp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_res0  <= '0;
      r_res1  <= '0;
      r_cout0 <= 1'b0;
      r_cout1 <= 1'b0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_a    <= w_grant ? req1_a   : req0_a;
        r_b    <= w_grant ? req1_b   : req0_b;
        r_sub  <= w_grant ? req1_sub : req0_sub;
        r_id   <= w_grant;
        r_last <= w_grant;
      end
      if (r_state == EXEC) begin
        if (r_id) begin
          r_res1  <= op_result;
          r_cout1 <= op_cout;
        end else begin
          r_res0  <= op_result;
          r_cout0 <= op_cout;
        end
      end
      // Completion counters saturate instead of wrapping.
      if (w_resp_hs) begin
        if (!r_id && r_cnt0 != '1) r_cnt0 <= r_cnt0 + 1'b1;
        if ( r_id && r_cnt1 != '1) r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

  assign req0_ready   = w_rdy0;
  assign req1_ready   = w_rdy1;
  assign resp0_valid  = (r_state == RESP) && !r_id;
  assign resp1_valid  = (r_state == RESP) &&  r_id;
  assign resp0_result = r_res0;
  assign resp0_cout   = r_cout0;
  assign resp1_result = r_res1;
  assign resp1_cout   = r_cout1;
  assign op_a         = r_a;
  assign op_b         = r_b;
  assign op_sub       = r_sub;
  assign op_en        = (r_state == EXEC);
  assign busy         = (r_state != IDLE);
  assign cnt0         = r_cnt0;
  assign cnt1         = r_cnt1;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Directed bench: round-robin instance (CNT_W=8) and fixed-priority instance (CNT_W=2)
// share one stimulus; each has its own behavioural adder/subtractor model.
module tb_addsub_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req0_sub, req1_valid, req1_sub;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       resp0_ready, resp1_ready;

  logic       rr_req0_ready, rr_req1_ready, rr_resp0_valid, rr_resp1_valid;
  logic [3:0] rr_resp0_result, rr_resp1_result, rr_op_a, rr_op_b;
  logic       rr_resp0_cout, rr_resp1_cout, rr_op_sub, rr_op_en, rr_busy;
  logic [7:0] rr_cnt0, rr_cnt1;
  logic [4:0] rr_alu;

  logic       fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid;
  logic [3:0] fp_resp0_result, fp_resp1_result, fp_op_a, fp_op_b;
  logic       fp_resp0_cout, fp_resp1_cout, fp_op_sub, fp_op_en, fp_busy;
  logic [1:0] fp_cnt0, fp_cnt1;
  logic [4:0] fp_alu;

  // Subtract is A + ~B + 1, so cout=1 means no borrow.
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 5'd1;
    else     return {1'b0, a} + {1'b0, b};
  endfunction

  assign rr_alu = alu(rr_op_a, rr_op_b, rr_op_sub);
  assign fp_alu = alu(fp_op_a, fp_op_b, fp_op_sub);

  addsub_share_arbiter #(.RR_EN(1'b1), .CNT_W(8)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .resp0_valid(rr_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(rr_resp0_result), .resp0_cout(rr_resp0_cout),
    .resp1_valid(rr_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(rr_resp1_result), .resp1_cout(rr_resp1_cout),
    .op_a(rr_op_a), .op_b(rr_op_b), .op_sub(rr_op_sub), .op_en(rr_op_en),
    .op_result(rr_alu[3:0]), .op_cout(rr_alu[4]),
    .busy(rr_busy), .cnt0(rr_cnt0), .cnt1(rr_cnt1)
  );

  addsub_share_arbiter #(.RR_EN(1'b0), .CNT_W(2)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .resp0_valid(fp_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(fp_resp0_result), .resp0_cout(fp_resp0_cout),
    .resp1_valid(fp_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(fp_resp1_result), .resp1_cout(fp_resp1_cout),
    .op_a(fp_op_a), .op_b(fp_op_b), .op_sub(fp_op_sub), .op_en(fp_op_en),
    .op_result(fp_alu[3:0]), .op_cout(fp_alu[4]),
    .busy(fp_busy), .cnt0(fp_cnt0), .cnt1(fp_cnt1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  // Single-requester op on the round-robin instance; entered and left at a negedge in IDLE.
  task automatic do_op(input logic id, input logic [3:0] a, input logic [3:0] b, input logic sub,
                       input logic [3:0] exp_res, input logic exp_cout);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub; resp1_ready = 1'b1;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub; resp0_ready = 1'b1;
    end
    #1;
    chk("op_ready_own",   id ? rr_req1_ready : rr_req0_ready, 1);
    chk("op_ready_other", id ? rr_req0_ready : rr_req1_ready, 0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("op_exec_en",   rr_op_en, 1);
    chk("op_exec_a",    rr_op_a, a);
    chk("op_exec_b",    rr_op_b, b);
    chk("op_exec_sub",  rr_op_sub, sub);
    chk("op_exec_nrsp", rr_resp0_valid | rr_resp1_valid, 0);
    cyc();
    chk("op_rsp_valid", id ? rr_resp1_valid  : rr_resp0_valid, 1);
    chk("op_rsp_other", id ? rr_resp0_valid  : rr_resp1_valid, 0);
    chk("op_rsp_res",   id ? rr_resp1_result : rr_resp0_result, exp_res);
    chk("op_rsp_cout",  id ? rr_resp1_cout   : rr_resp0_cout, exp_cout);
    cyc();
    chk("op_done_busy", rr_busy, 0);
    chk("op_done_en",   rr_op_en, 0);
  endtask

  initial begin
    logic g;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd0; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd0; req1_b = 4'd0; req1_sub = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    // Reset state, with valids high to show ready is forced low.
    cyc(); cyc();
    chk("rst_busy",   rr_busy, 0);
    chk("rst_rdy0",   rr_req0_ready, 0);
    chk("rst_rdy1",   rr_req1_ready, 0);
    chk("rst_rsp",    {rr_resp0_valid, rr_resp1_valid}, 0);
    chk("rst_op",     {rr_op_a, rr_op_b, rr_op_sub, rr_op_en}, 0);
    chk("rst_res",    {rr_resp0_result, rr_resp0_cout, rr_resp1_result, rr_resp1_cout}, 0);
    chk("rst_cnt",    {rr_cnt0, rr_cnt1}, 0);
    do_reset();

    // Single requester adds and subtracts.
    do_op(1'b0, 4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0);
    chk("cnt0_one",     rr_cnt0, 1);
    chk("op_hold_a",    rr_op_a, 4'b0011);
    do_op(1'b1, 4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1);
    do_op(1'b1, 4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0);
    do_op(1'b1, 4'b1001, 4'b1000, 1'b0, 4'b0001, 1'b1);
    chk("cnt1_three",   rr_cnt1, 3);
    chk("cnt0_still",   rr_cnt0, 1);

    // Continuous contention: RR alternates, FP always serves req0.
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd3; req1_sub = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    g = 1'b0;
    for (int k = 0; k < 24; k++) begin
      #1;
      chk("rr_not_both", rr_req0_ready & rr_req1_ready, 0);
      chk("fp_rdy1_low", fp_req1_ready, 0);
      if (k % 3 == 0) begin
        chk("rr_grant", {rr_req1_ready, rr_req0_ready}, g ? 2'b10 : 2'b01);
        chk("fp_grant", fp_req0_ready, 1);
        g = ~g;
      end else begin
        chk("rr_noready", {rr_req1_ready, rr_req0_ready}, 0);
      end
      cyc();
    end
    chk("rr_cnt0_4",  rr_cnt0, 4);
    chk("rr_cnt1_4",  rr_cnt1, 4);
    chk("fp_cnt0_sat", fp_cnt0, 3);
    chk("fp_cnt1_0",  fp_cnt1, 0);

    // Backpressure: resp0 held 5 cycles while req1 waits.
    do_reset();
    req0_valid = 1'b1; req0_a = 4'b1001; req0_b = 4'b1000; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd4; req1_sub = 1'b1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
    chk("bp_first_req0", {rr_req1_ready, rr_req0_ready}, 2'b01);
    cyc();
    req0_valid = 1'b0;
    chk("bp_exec_rdy1", rr_req1_ready, 0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", rr_resp0_valid, 1);
      chk("bp_res",   {rr_resp0_result, rr_resp0_cout}, {4'b0001, 1'b1});
      chk("bp_rdy1",  rr_req1_ready, 0);
      cyc();
    end
    resp0_ready = 1'b1;
    #1;
    chk("bp_valid_hs", rr_resp0_valid, 1);
    cyc();
    chk("bp_req1_next", rr_req1_ready, 1);
    cyc();
    req1_valid = 1'b0;
    chk("bp_req1_exec_a", rr_op_a, 4'd6);
    resp1_ready = 1'b1;
    cyc();
    chk("bp_req1_res", {rr_resp1_valid, rr_resp1_result, rr_resp1_cout}, {1'b1, 4'd2, 1'b1});
    cyc();

    // Reset mid-EXEC drops the op; afterwards req0 wins first contention.
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2; req0_sub = 1'b0;
    cyc();
    chk("mid_exec", rr_op_en, 1);
    rst = 1'b1;
    cyc();
    chk("mid_busy",  rr_busy, 0);
    chk("mid_rsp",   {rr_resp0_valid, rr_resp1_valid}, 0);
    chk("mid_cnt",   {rr_cnt0, rr_cnt1}, 0);
    chk("mid_rdy",   {rr_req0_ready, rr_req1_ready}, 0);
    chk("mid_op",    {rr_op_a, rr_op_en}, 0);
    rst = 1'b0;
    req0_a = 4'd6; req0_b = 4'd1; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5; req1_sub = 1'b0;
    #1;
    chk("mid_grant0", {rr_req1_ready, rr_req0_ready}, 2'b01);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("mid_new_a", rr_op_a, 4'd6);
    cyc();
    chk("mid_new_res", {rr_resp0_valid, rr_resp0_result}, {1'b1, 4'd7});
    cyc();
    chk("mid_cnt0_1", rr_cnt0, 1);

    // Saturation with CNT_W=2 from a single requester.
    do_reset();
    for (int k = 0; k < 5; k++) do_op(1'b0, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0);
    chk("sat_fp_cnt0", fp_cnt0, 3);
    chk("sat_rr_cnt0", rr_cnt0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_share_arbiter.md
Name: addsub_share_arbiter

Overview:
- Shares one four_bit_adder_subtractor instance between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates (round-robin or fixed priority), latches the winner's operands, and drives the shared unit for one cycle. It then captures Result/Cout and holds the response until the requester accepts it.
- It sits between the requesting blocks and the shared adder/subtractor, which is instantiated outside and wired to the op_* ports.

Parameters:
- RR_EN, 1: 1 = round-robin between req0/req1; 0 = fixed priority, req0 always wins.
- CNT_W, 8: width of the per-requester completed-operation counters.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  request 0 accepted this cycle when req0_valid also high
- req0_a  in  4  operand A, requester 0
- req0_b  in  4  operand B, requester 0
- req0_sub  in  1  1 = A-B, 0 = A+B, requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  as above, requester 1
- resp0_valid  out  1  response for requester 0 available
- resp0_ready  in  1  requester 0 takes response
- resp0_result  out  4  registered Result for requester 0
- resp0_cout  out  1  registered Cout for requester 0
- resp1_valid, resp1_ready, resp1_result, resp1_cout  as above, requester 1
- op_a  out  4  to shared unit A
- op_b  out  4  to shared unit B
- op_sub  out  1  to shared unit subtract
- op_en  out  1  high during EXEC (observability only)
- op_result  in  4  from shared unit Result (combinational)
- op_cout  in  1  from shared unit Cout
- busy  out  1  state != IDLE
- cnt0  out  CNT_W  completed ops, requester 0, saturating
- cnt1  out  CNT_W  completed ops, requester 1, saturating

Behaviour:
- FSM states: IDLE -> EXEC -> RESP -> IDLE. One operation is in flight at a time.
- IDLE, grant computed combinationally from valids and last_grant:
  - RR_EN=1: both valid -> requester != last_grant; one valid -> that one.
  - RR_EN=0: req0 if valid, else req1.
  - reqN_ready = (state==IDLE) && grant==N && !rst. At most one ready is high; ready is never high outside IDLE.
- Acceptance is an edge with valid && ready. On that edge: latch a/b/sub/requester id, set last_grant = id, go to EXEC.
- A valid dropped before acceptance is legal; arbitration is re-evaluated each IDLE cycle.
- EXEC (exactly 1 cycle):
  - op_a/op_b/op_sub driven from the latched registers; op_en=1.
  - At the end of EXEC, op_result/op_cout are captured into the response registers of the granted requester; go to RESP.
- RESP:
  - respN_valid=1 for the granted requester only; result/cout held stable.
  - On respN_valid && respN_ready: increment cntN (saturate at 2^CNT_W-1, no wrap), go to IDLE.
  - resp_ready low holds RESP indefinitely; no new request is accepted meanwhile.
- Outside EXEC, op_a/op_b/op_sub hold their last value; op_en=0.
- Timing:
  - resp_valid rises 2 cycles after the acceptance edge.
  - With resp_ready tied high, minimum throughput is one op per 3 cycles.
  - Both requesters continuously valid under RR_EN=1 -> grants alternate strictly 0,1,0,1.
- No arithmetic inside this block; result and cout are passed through unmodified. Subtract convention, Result width and Cout semantics are exactly those of the shared unit.
- Reset (rst high at a clock edge, in any state including mid-EXEC/RESP):
  - state=IDLE, in-flight op discarded.
  - last_grant=1, so req0 wins the first contention.
  - All ready/valid outputs 0; op_a/op_b/op_sub/op_en=0; resp results/couts=0; busy=0; cnt0=cnt1=0.
  - While rst is high, ready outputs are forced 0.

Test Plan:
- Only req0_valid, A=0011, B=0101, sub=0, resp0_ready=1 -> req0_ready high in IDLE; resp0_valid 2 cycles after accept with result=1000, cout=0; cnt0=1; resp1_valid never asserted.
- req1 sub ops with the real four_bit_adder_subtractor:
  - A=0101, B=0011 -> result=0010, cout=1.
  - A=0011, B=0101 -> result=1110, cout=0.
  - Add A=1001, B=1000 -> result=0001, cout=1.
- Both valid continuously, RR_EN=1, resp_ready=1 -> grant order 0,1,0,1,... with one accept every 3 cycles; after 8 ops cnt0=4, cnt1=4; reqN_ready never both high.
- Same stimulus with RR_EN=0 -> only req0 granted; req1_ready stays 0.
- resp0_ready held low 5 cycles in RESP with req1_valid high -> resp0_valid/result/cout stable for all 5; req1_ready=0 throughout; req1 accepted in the first IDLE cycle after the resp0 handshake.
- rst pulsed during EXEC -> next cycle busy=0, all resp_valid=0, counters 0, no response for the dropped op; then both valid -> req0 granted first.
- Ops to one requester with CNT_W=2 -> cnt reaches 3 and stays 3.
